// File: rtl/pipe_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl_if
// Bundles the signals between the two instruction requesters, the issue
// scheduler and pipeline stage 1.
//   master : requester/pipeline side. Drives hold, the req/field inputs and
//            observes the grants, the issue port, illegal and the counters.
//   slave  : the issue scheduler (pipe_issue_ctrl).
// Signals:
//   hold                          system freeze, no grants while high
//   req0/req1                     request, held until the matching grant
//   rs1_k, rs2_k, rd_k, func_k    4-bit instruction fields of requester k
//   addr_k                        8-bit memory address of requester k
//   gnt0/gnt1                     combinational grant, consumed at the edge
//   issue_valid, issue_*          registered issue port to stage 1
//   illegal                       registered pulse: granted func was 12..15
//   issue_cnt, stall_cnt          wrapping statistics counters
// ---------------------------------------------------------------------------
interface pipe_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hold;
    logic             req0;
    logic [3:0]       rs1_0;
    logic [3:0]       rs2_0;
    logic [3:0]       rd_0;
    logic [3:0]       func_0;
    logic [7:0]       addr_0;
    logic             req1;
    logic [3:0]       rs1_1;
    logic [3:0]       rs2_1;
    logic [3:0]       rd_1;
    logic [3:0]       func_1;
    logic [7:0]       addr_1;
    logic             gnt0;
    logic             gnt1;
    logic             issue_valid;
    logic [3:0]       issue_rs1;
    logic [3:0]       issue_rs2;
    logic [3:0]       issue_rd;
    logic [3:0]       issue_func;
    logic [7:0]       issue_addr;
    logic             illegal;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hold,
        output req0, rs1_0, rs2_0, rd_0, func_0, addr_0,
        output req1, rs1_1, rs2_1, rd_1, func_1, addr_1,
        input  gnt0, gnt1,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr,
        input  illegal, issue_cnt, stall_cnt
    );

    modport slave (
        input  hold,
        input  req0, rs1_0, rs2_0, rd_0, func_0, addr_0,
        input  req1, rs1_1, rs2_1, rd_1, func_1, addr_1,
        output gnt0, gnt1,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr,
        output illegal, issue_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
// Issue scheduler in front of the 4-stage ALU/regbank/mem pipeline. Two
// requesters are arbitrated round-robin onto one registered issue port.
// Because the pipeline has no forwarding, read-after-write hazards are
// blocked by a shift-register scoreboard of recently issued destinations.
// Illegal func codes (12..15) are consumed but not issued.
//
// Optional feature (macro ISSUE_HAZARD_CHECK_EN):
//   defined     : scoreboard built, hazarded requesters stall, stall_cnt counts
//   not defined : no scoreboard, no hazard stalls, stall_cnt tied to 0
//
// Ports:
//   clk1  rising-edge system clock
//   rst   asynchronous active-high reset
//   bus   pipe_issue_ctrl_if.slave (requests, grants, issue port, counters)
//
// Parameters:
//   HAZ_DEPTH  cycles an issued rd stays pending after its grant (1..8)
//   CNT_W      width of issue_cnt / stall_cnt
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
    parameter int HAZ_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic               clk1,
    input  logic               rst,
    pipe_issue_ctrl_if.slave   bus
);

    // rr_reg = 0 favours requester 0, 1 favours requester 1.
    logic             rr_reg;
    logic             issue_valid_reg;
    logic [3:0]       issue_rs1_reg;
    logic [3:0]       issue_rs2_reg;
    logic [3:0]       issue_rd_reg;
    logic [3:0]       issue_func_reg;
    logic [7:0]       issue_addr_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] issue_cnt_reg;

    logic       hazard0;
    logic       hazard1;
    logic       elig0;
    logic       elig1;
    logic       gnt0;
    logic       gnt1;
    logic       grant_any;
    logic       grant_legal;
    logic [3:0] sel_rs1;
    logic [3:0] sel_rs2;
    logic [3:0] sel_rd;
    logic [3:0] sel_func;
    logic [7:0] sel_addr;

`ifdef ISSUE_HAZARD_CHECK_EN
    // Scoreboard: entry 0 is the most recent grant; entries age by one
    // position per clock regardless of hold, so hazards drain while frozen.
    logic                 sb_v_reg  [HAZ_DEPTH];
    logic [3:0]           sb_rd_reg [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] hit0;
    logic [HAZ_DEPTH-1:0] hit1;
    logic                 stall;
    logic [CNT_W-1:0]     stall_cnt_reg;

    // The scoreboard only holds earlier grants, so an instruction whose rd
    // matches its own sources never blocks itself.
    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_sb_cmp
        assign hit0[gi] = sb_v_reg[gi] &
                          ((sb_rd_reg[gi] == bus.rs1_0) | (sb_rd_reg[gi] == bus.rs2_0));
        assign hit1[gi] = sb_v_reg[gi] &
                          ((sb_rd_reg[gi] == bus.rs1_1) | (sb_rd_reg[gi] == bus.rs2_1));
    end

    assign hazard0 = |hit0;
    assign hazard1 = |hit1;

    // A stall cycle: not frozen, someone is asking, yet nobody was granted,
    // which can only mean every active requester is hazarded.
    assign stall = ~bus.hold & (bus.req0 | bus.req1) & ~grant_any;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_v_reg[i]  <= 1'b0;
                sb_rd_reg[i] <= 4'd0;
            end
            stall_cnt_reg <= '0;
        end else begin
            sb_v_reg[0]  <= grant_legal;
            sb_rd_reg[0] <= sel_rd;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                sb_v_reg[i]  <= sb_v_reg[i-1];
                sb_rd_reg[i] <= sb_rd_reg[i-1];
            end
            if (stall) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
`else
    assign hazard0       = 1'b0;
    assign hazard1       = 1'b0;
    assign bus.stall_cnt = '0;
`endif

    // Reset is folded into eligibility so grants are low while rst is high
    // even though the arbiter itself is combinational.
    assign elig0 = bus.req0 & ~hazard0 & ~bus.hold & ~rst;
    assign elig1 = bus.req1 & ~hazard1 & ~bus.hold & ~rst;

    // A lone eligible requester wins even when the pointer favours the
    // other one, so a hazarded requester never blocks its neighbour.
    assign gnt0 = elig0 & (~elig1 | ~rr_reg);
    assign gnt1 = elig1 & (~elig0 |  rr_reg);

    assign grant_any = gnt0 | gnt1;

    assign sel_rs1  = gnt1 ? bus.rs1_1  : bus.rs1_0;
    assign sel_rs2  = gnt1 ? bus.rs2_1  : bus.rs2_0;
    assign sel_rd   = gnt1 ? bus.rd_1   : bus.rd_0;
    assign sel_func = gnt1 ? bus.func_1 : bus.func_0;
    assign sel_addr = gnt1 ? bus.addr_1 : bus.addr_0;

    // func 12..15 is the top quarter of the code space.
    assign grant_legal = grant_any & (sel_func[3:2] != 2'b11);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rr_reg          <= 1'b0;
            issue_valid_reg <= 1'b0;
            issue_rs1_reg   <= 4'd0;
            issue_rs2_reg   <= 4'd0;
            issue_rd_reg    <= 4'd0;
            issue_func_reg  <= 4'd0;
            issue_addr_reg  <= 8'd0;
            illegal_reg     <= 1'b0;
            issue_cnt_reg   <= '0;
        end else begin
            issue_valid_reg <= grant_legal;
            illegal_reg     <= grant_any & ~grant_legal;
            if (grant_any) begin
                // Pointer moves to whichever requester did not win.
                rr_reg         <= gnt0;
                issue_rs1_reg  <= sel_rs1;
                issue_rs2_reg  <= sel_rs2;
                issue_rd_reg   <= sel_rd;
                issue_func_reg <= sel_func;
                issue_addr_reg <= sel_addr;
            end
            if (grant_legal) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.issue_valid = issue_valid_reg;
    assign bus.issue_rs1   = issue_rs1_reg;
    assign bus.issue_rs2   = issue_rs2_reg;
    assign bus.issue_rd    = issue_rd_reg;
    assign bus.issue_func  = issue_func_reg;
    assign bus.issue_addr  = issue_addr_reg;
    assign bus.illegal     = illegal_reg;
    assign bus.issue_cnt   = issue_cnt_reg;

endmodule
